// File: rtl/rr_pkg.sv
// rr_pkg -- shared definitions for the round-robin packet requester.
// Holds the per-channel FSM state encoding and default sizing constants.
package rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } chan_state_t;

    localparam int N_DEF     = 8;   // requester channels
    localparam int LEN_W_DEF = 4;   // descriptor length width (beats-1)
    localparam int DEPTH_DEF = 2;   // descriptor buffer entries per channel

endpackage

// File: rtl/rr_packet_requester_if.sv
// rr_packet_requester_if -- descriptor/arbiter bundle for rr_packet_requester.
//   desc_valid/desc_len/desc_ready : per-channel descriptor offer and buffer space
//   grants                         : one-hot grant from the packet arbiter
//   req/req_is_last                : per-channel beat request, final-beat marker
//   pkt_done/grant_err             : packet-complete pulse, sticky grant error
// slave modport is the requester side; master is the driver/arbiter side.
interface rr_packet_requester_if
    import rr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    logic [N-1:0]            desc_valid;
    logic [N-1:0][LEN_W-1:0] desc_len;
    logic [N-1:0]            desc_ready;
    logic [N-1:0]            grants;
    logic [N-1:0]            req;
    logic [N-1:0]            req_is_last;
    logic [N-1:0]            pkt_done;
    logic [N-1:0]            grant_err;

    modport master (
        output desc_valid, desc_len, grants,
        input  desc_ready, req, req_is_last, pkt_done, grant_err
    );

    modport slave (
        input  desc_valid, desc_len, grants,
        output desc_ready, req, req_is_last, pkt_done, grant_err
    );
endinterface

// File: rtl/rr_req_channel.sv
// rr_req_channel -- one requester channel: descriptor FIFO, IDLE/SEND FSM,
// beat counter and sticky grant-error flag.
//   clk, rst      : clock, async active-high reset
//   desc_valid/desc_len/desc_ready : descriptor push handshake
//   grant         : this channel's arbiter grant bit
//   req, req_is_last, pkt_done, grant_err : channel status outputs
module rr_req_channel
    import rr_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             desc_valid,
    input  logic [LEN_W-1:0] desc_len,
    output logic             desc_ready,
    input  logic             grant,
    output logic             req,
    output logic             req_is_last,
    output logic             pkt_done,
    output logic             grant_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    chan_state_t      state;
    logic [LEN_W-1:0] cnt;
    logic             push, pop, xfer, at_last, fifo_empty;

    assign req         = (state == SEND);
    assign at_last     = (cnt == '0);
    assign req_is_last = req && at_last;
    assign xfer        = req && grant;
    assign fifo_empty  = (count == '0);
    assign push        = desc_valid && desc_ready;
    // Head is consumed either to start from IDLE or to chain the next packet
    // on the last beat, so there is no bubble between packets.
    assign pop         = !fifo_empty && ((state == IDLE) || (xfer && at_last));

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= desc_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            desc_ready <= 1'b1;
            pkt_done   <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            count      <= count_nxt;
            desc_ready <= (count_nxt < FULL);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            pkt_done   <= xfer && at_last;
            if (grant && !req) grant_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= SEND;
                        cnt   <= mem[rd_ptr];
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (!at_last)  cnt   <= cnt - 1'b1;
                        else if (pop)  cnt   <= mem[rd_ptr];
                        else           state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rr_packet_requester.sv
// rr_packet_requester -- N independent packet requesters feeding a
// round-robin packet arbiter. Each channel buffers descriptors (length-1)
// and requests one beat per grant until its packet completes.
//   clk, rst : clock, async active-high reset
//   bus      : rr_packet_requester_if slave (descriptors in, grants in,
//              req/req_is_last/pkt_done/grant_err/desc_ready out)
module rr_packet_requester
    import rr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_packet_requester_if.slave bus
);
    for (genvar i = 0; i < N; i++) begin : g_ch
        rr_req_channel #(
            .LEN_W (LEN_W),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .desc_valid  (bus.desc_valid[i]),
            .desc_len    (bus.desc_len[i]),
            .desc_ready  (bus.desc_ready[i]),
            .grant       (bus.grants[i]),
            .req         (bus.req[i]),
            .req_is_last (bus.req_is_last[i]),
            .pkt_done    (bus.pkt_done[i]),
            .grant_err   (bus.grant_err[i])
        );
    end

endmodule

// File: tb/tb_rr_packet_requester.sv
// tb_rr_packet_requester -- directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model; grants come
// either from a manual pattern or a round-robin arbiter model.
module tb_rr_packet_requester;
    import rr_pkg::*;

    localparam int N = 8, LEN_W = 4, DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_packet_requester_if #(.N(N), .LEN_W(LEN_W)) bus ();

    rr_packet_requester #(.N(N), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0, errors = 0;

    // Reference model: pending descriptors, packet in flight, beats left.
    int unsigned pend [N][$];
    bit  active [N];
    int  left   [N];
    bit  m_ready[N], m_done[N], m_err[N];
    int  rr_ptr;

    bit                      use_arb;
    logic [N-1:0]            g_manual;
    logic [N-1:0]            v_in;
    logic [N-1:0][LEN_W-1:0] l_in;

    // Observed statistics taken from DUT outputs.
    int req_cnt[N], last_xfer[N], done_cnt[N], xfer_cnt[N], acc_cnt[N];
    int run[N], max_run[N];

    task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            req_cnt[i] = 0; last_xfer[i] = 0; done_cnt[i] = 0;
            xfer_cnt[i] = 0; acc_cnt[i] = 0; run[i] = 0; max_run[i] = 0;
        end
    endtask

    task automatic check_all(string ph);
        logic [N-1:0] er, el, ed, ee, ey;
        for (int i = 0; i < N; i++) begin
            er[i] = active[i];
            el[i] = active[i] && (left[i] == 1);
            ed[i] = m_done[i];
            ee[i] = m_err[i];
            ey[i] = m_ready[i];
        end
        chk({ph, ".req"},         bus.req,         er);
        chk({ph, ".req_is_last"}, bus.req_is_last, el);
        chk({ph, ".pkt_done"},    bus.pkt_done,    ed);
        chk({ph, ".grant_err"},   bus.grant_err,   ee);
        chk({ph, ".desc_ready"},  bus.desc_ready,  ey);
    endtask

    function automatic logic [N-1:0] arb_pick();
        logic [N-1:0] g = '0;
        for (int k = 0; k < N; k++) begin
            int idx = (rr_ptr + k) % N;
            if (active[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            active[i] = 0; left[i] = 0;
            m_ready[i] = 1; m_done[i] = 0; m_err[i] = 0;
        end
        rr_ptr = 0;
    endtask

    // Called one time unit after a rising edge: apply inputs, check, advance.
    task automatic step(string ph);
        logic [N-1:0] g;
        g = use_arb ? arb_pick() : g_manual;
        bus.grants     = g;
        bus.desc_valid = v_in;
        bus.desc_len   = l_in;
        #1;
        check_all(ph);
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                req_cnt[i]++; run[i]++;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end else run[i] = 0;
            if (bus.req[i] && g[i]) begin
                xfer_cnt[i]++;
                if (bus.req_is_last[i]) last_xfer[i]++;
            end
            if (bus.pkt_done[i]) done_cnt[i]++;
            if (v_in[i] && bus.desc_ready[i]) acc_cnt[i]++;
        end
        for (int i = 0; i < N; i++) begin
            bit x, push;
            x    = active[i] && g[i];
            push = v_in[i] && m_ready[i];
            if (g[i] && !active[i]) m_err[i] = 1;
            m_done[i] = x && (left[i] == 1);
            if (active[i]) begin
                if (x) begin
                    if (left[i] > 1)              left[i]--;
                    else if (pend[i].size() > 0)  left[i] = pend[i].pop_front() + 1;
                    else                          active[i] = 0;
                end
            end else if (pend[i].size() > 0) begin
                active[i] = 1;
                left[i]   = pend[i].pop_front() + 1;
            end
            if (push) pend[i].push_back(int'(l_in[i]));
            m_ready[i] = pend[i].size() < DEPTH;
        end
        if (use_arb)
            for (int k = 0; k < N; k++) if (g[k]) rr_ptr = (k + 1) % N;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v_in = '0; l_in = '0; g_manual = '0; use_arb = 0;
        bus.desc_valid = '0; bus.desc_len = '0; bus.grants = '0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b0;
        clear_stats();
    endtask

    initial begin
        v_in = '0; l_in = '0; g_manual = '0; use_arb = 0;
        do_reset();

        // Single beat on channel 0, grant held high.
        g_manual = 8'h01; v_in = 8'h01; l_in[0] = 4'd0;
        step("single");
        v_in = '0;
        repeat (5) step("single");
        chk_int("single.req_cycles", req_cnt[0], 1);
        chk_int("single.last_xfer", last_xfer[0], 1);
        chk_int("single.done", done_cnt[0], 1);
        do_reset();

        // Back-to-back lengths 2 then 1 on channel 3.
        g_manual = 8'h08; v_in = 8'h08; l_in[3] = 4'd2;
        step("b2b");
        l_in[3] = 4'd1;
        step("b2b");
        v_in = '0;
        repeat (8) step("b2b");
        chk_int("b2b.req_run", max_run[3], 5);
        chk_int("b2b.req_cycles", req_cnt[3], 5);
        chk_int("b2b.last_xfer", last_xfer[3], 2);
        chk_int("b2b.done", done_cnt[3], 2);
        do_reset();

        // Grant stall: length 3 on channel 1, toggling grant.
        v_in = 8'h02; l_in[1] = 4'd3; g_manual = 8'h02;
        step("stall");
        v_in = '0;
        for (int c = 0; c < 14; c++) begin
            g_manual = (c % 2 == 0) ? 8'h00 : 8'h02;
            step("stall");
        end
        chk_int("stall.xfers", xfer_cnt[1], 4);
        chk_int("stall.last_xfer", last_xfer[1], 1);
        chk_int("stall.done", done_cnt[1], 1);
        do_reset();

        // Full buffer on channel 5 with its grant held low.
        v_in = 8'h20; l_in[5] = 4'd1; g_manual = '0;
        repeat (3) step("full");
        chk("full.ready_low", bus.desc_ready & 8'h20, 8'h00);
        repeat (3) step("full");
        chk_int("full.accepted", acc_cnt[5], 3);
        g_manual = 8'h20;
        repeat (4) step("full");
        v_in = '0;
        chk_int("full.accepted_after", acc_cnt[5], 4);
        repeat (8) step("full");
        do_reset();

        // Grant error on channel 6, then reset mid-packet on channel 2.
        g_manual = 8'h40;
        repeat (2) step("err");
        g_manual = '0;
        repeat (2) step("err");
        chk("err.sticky", bus.grant_err & 8'h40, 8'h40);
        v_in = 8'h04; l_in[2] = 4'd5;
        step("midpkt");
        v_in = '0; g_manual = 8'h04;
        repeat (3) step("midpkt");
        do_reset();
        repeat (4) step("after_rst");
        chk_int("midpkt.no_done", done_cnt[2], 0);

        // All channels length 0 against the arbiter.
        use_arb = 1; v_in = '1; l_in = '0;
        step("integ");
        v_in = '0;
        repeat (10) step("integ");
        for (int i = 0; i < N; i++) chk_int("integ.done_once", done_cnt[i], 1);
        do_reset();

        // Randomized traffic with mixed grant sources and a mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            use_arb  = ((c / 50) % 3) != 2;
            v_in     = N'($urandom);
            for (int i = 0; i < N; i++) l_in[i] = LEN_W'($urandom_range(0, 15));
            g_manual = N'($urandom) & N'($urandom);
            step("rand");
        end
        v_in = '0; use_arb = 1;
        repeat (60) step("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_packet_requester.md
RR_PACKET_REQUESTER -- requirements
Module: rr_packet_requester

Interface
REQ-001 Parameter N, default 8, number of requester channels; matches the arbiter port count.
REQ-002 Parameter LEN_W, default 4, descriptor length width; packet beats = desc_len+1, range 1..16.
REQ-003 Parameter DEPTH, default 2, descriptor buffer entries per channel; power of two, at least 2.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 desc_valid  input  N  per-channel descriptor offer.
REQ-007 desc_len  input  N x LEN_W  per-channel packet length minus one.
REQ-008 desc_ready  output  N  per-channel descriptor buffer not full.
REQ-009 grants  input  N  one-hot grant from the packet arbiter.
REQ-010 req  output  N  per-channel beat request to the arbiter.
REQ-011 req_is_last  output  N  current requested beat is the final beat of its packet.
REQ-012 pkt_done  output  N  one-cycle pulse, channel's last beat transferred.
REQ-013 grant_err  output  N  sticky flag, grant seen without request.

Function
REQ-014 Descriptor accept: desc_valid[i] and desc_ready[i] at a clock edge; the length is pushed into channel i's FIFO.
REQ-015 desc_ready[i] is 1 when the channel FIFO holds fewer than DEPTH entries; it is registered and ignores same-cycle pops.
REQ-016 Beat transfer on channel i: req[i] and grants[i] both 1 at a clock edge.
REQ-017 Channel FSM states: IDLE and SEND.
REQ-018 IDLE -> SEND when the FIFO is non-empty: pop the head and load beat counter = desc_len.
- The load happens one cycle after the push at the earliest.
REQ-019 In SEND, req[i] is 1, driven combinationally from state (no added latency).
REQ-020 req_is_last[i] = req[i] and (counter == 0); otherwise 0.
REQ-021 Non-last transfer: counter decrements by 1.
- Counter is LEN_W bits and never wraps below 0.
REQ-022 Last transfer, FIFO non-empty: pop the next descriptor and stay in SEND; the next packet's first beat is requested the following cycle, with no bubble.
REQ-023 Last transfer, FIFO empty: return to IDLE.
REQ-024 pkt_done[i] is registered, high for exactly the cycle after the last transfer.
REQ-025 Push and pop in the same cycle: both take effect and the occupancy is unchanged.
- A push into a full FIFO is impossible because desc_ready=0.
REQ-026 No grant in SEND: req and req_is_last hold their values and the counter holds; there is no timeout.
REQ-027 grants[i]=1 while req[i]=0: grant_err[i] sets and stays set until reset; no state change.
REQ-028 Channels are fully independent; simultaneous events on different channels do not interact.
REQ-029 Non-one-hot grants are not checked here; each channel uses only its own bit.

Reset
REQ-030 rst asserted: FIFOs empty, every FSM to IDLE, counters 0.
REQ-031 Output values in reset: req=0, req_is_last=0, pkt_done=0, grant_err=0, desc_ready=all ones.
REQ-032 Reset mid-packet abandons the packet and all buffered descriptors; no pkt_done is generated.
REQ-033 First descriptor accept is possible on the first edge after rst deasserts.

Structure
REQ-034 Shared package rr_pkg holds the channel state enum (IDLE, SEND) and the default N/LEN_W/DEPTH constants.
REQ-035 One sub-module, rr_req_channel, contains one channel's FIFO, FSM, counter and error flag.
- The top generate-instantiates N copies; no logic crosses channels.

Verification
REQ-036 Benches instantiate rr_packet_requester driving simple_rr_packet_arbiter (N=8), plus a standalone channel bench with a forced grants pattern.
REQ-037 Single beat: desc_len[0]=0 pushed, grants[0]=1 continuously.
- Response: req[0] and req_is_last[0] high for one cycle, pkt_done[0] the next cycle, channel returns to IDLE.
REQ-038 Back-to-back: lengths 2 then 1 pushed on channel 3, grant held high.
- Response: req[3] high for 5 consecutive cycles.
- req_is_last[3] high on the 3rd and 5th beats; two pkt_done pulses.
REQ-039 Grant stall: length 3 on channel 1, grants[1] toggling 1,0,1,0,...
- Response: exactly 4 transfers, counter holds through the 0 cycles, req_is_last only on the 4th transfer.
REQ-040 Full buffer: 3 descriptors offered to channel 5 while its grant is held 0.
- Response: the first enters SEND, the next two fill the FIFO and desc_ready[5]=0.
- The 4th offer is stalled until the first packet completes.
REQ-041 Error and reset: grants[6]=1 with req[6]=0 sets grant_err[6]; it stays set.
- Then rst mid-packet on channel 2 clears all outputs to the REQ-031 values, and no pkt_done is seen.
REQ-042 Integrated: all 8 channels given length 0 against the arbiter.
- Response: grants rotate one channel per cycle and each pkt_done fires exactly once within 8 cycles.
